// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// gpu_pkg : shared types for the pixel write path (arbiter state, lane entry)
// Rev 1.0
// ============================================================================
package gpu_pkg;

    // Upper bounds for the lane entry fields; instances narrower than these
    // zero-extend into the struct and the unused bits are trimmed away.
    localparam int unsigned PIX_ADDR_MAX_W = 64;
    localparam int unsigned PIX_DATA_MAX_W = 64;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [PIX_ADDR_MAX_W-1:0] addr;
        logic [PIX_DATA_MAX_W-1:0] data;
    } pixel_entry_t;

    function automatic int unsigned lane_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// pixel_fifo : per-lane pointer FIFO; a push into a full FIFO lands when the
//              same cycle pops. Rev 1.0
// ============================================================================
module pixel_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(rd_en);
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// pixel_write_arbiter : round-robin merge of per-lane pixel FIFOs onto one
//   memory write master. Optional macro: PIXEL_WRITE_DROP_COUNT_EN. Rev 1.0
// ============================================================================
module pixel_write_arbiter
    import gpu_pkg::*;
#(
    parameter int          CORES_COUNT   = 10,
    parameter int          COLOR_WIDTH   = 16,
    parameter int          BUFFER_ADDR_W = 32,
    parameter int          FIFO_DEPTH    = 8,
    parameter int unsigned FB_BASE       = 0,
    parameter int unsigned CORE_STRIDE   = 192000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [COLOR_WIDTH-1:0]   ppu_data    [0:CORES_COUNT-1],
    input  logic [BUFFER_ADDR_W-1:0] ppu_address [0:CORES_COUNT-1],
    input  logic                     ppu_valid   [0:CORES_COUNT-1],
    input  logic                     eoc_in,
    output logic [BUFFER_ADDR_W-1:0] avm_address,
    output logic [COLOR_WIDTH-1:0]   avm_writedata,
    output logic                     avm_write,
    input  logic                     avm_waitrequest,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overflow
`ifdef PIXEL_WRITE_DROP_COUNT_EN
    ,
    output logic [31:0]              drop_count
`endif
);

    localparam int LANE_W  = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1;
    localparam int ENTRY_W = BUFFER_ADDR_W + COLOR_WIDTH;

    logic [CORES_COUNT-1:0] fifo_full, fifo_empty, fifo_pop, fifo_drop;
    logic [ENTRY_W-1:0]     fifo_dout [0:CORES_COUNT-1];

    arb_state_t               state_q, state_d;
    logic [LANE_W-1:0]        grant_q, grant_d;
    logic [LANE_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                     avm_write_q, avm_write_d;
    logic [BUFFER_ADDR_W-1:0] avm_address_q, avm_address_d;
    logic [COLOR_WIDTH-1:0]   avm_writedata_q, avm_writedata_d;
    logic                     pending_q, pending_d;
    logic                     overflow_q, overflow_d;

    logic                     sel_found;
    logic [LANE_W-1:0]        sel_lane;
    logic [LANE_W-1:0]        cand;
    pixel_entry_t             head;
    logic                     all_empty;

    generate
        for (genvar g = 0; g < CORES_COUNT; g++) begin : g_lane
            pixel_fifo #(
                .WIDTH (ENTRY_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset_n (reset_n),
                .push    (ppu_valid[g]),
                .pop     (fifo_pop[g]),
                .din     ({ppu_address[g], ppu_data[g]}),
                .dout    (fifo_dout[g]),
                .full    (fifo_full[g]),
                .empty   (fifo_empty[g])
            );
            assign fifo_pop[g]  = (state_q == ST_WRITE) && !avm_waitrequest &&
                                  (grant_q == LANE_W'(g));
            assign fifo_drop[g] = ppu_valid[g] && fifo_full[g] && !fifo_pop[g];
        end
    endgenerate

    assign all_empty = &fifo_empty;

    // First non-empty lane scanning upward from rr_ptr with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_lane  = '0;
        cand      = '0;
        for (int i = 0; i < CORES_COUNT; i++) begin
            cand = LANE_W'(lane_wrap(32'(rr_ptr_q) + 32'(i), 32'(CORES_COUNT)));
            if (!sel_found && !fifo_empty[cand]) begin
                sel_found = 1'b1;
                sel_lane  = cand;
            end
        end
        head.addr = PIX_ADDR_MAX_W'(fifo_dout[sel_lane][ENTRY_W-1:COLOR_WIDTH]);
        head.data = PIX_DATA_MAX_W'(fifo_dout[sel_lane][COLOR_WIDTH-1:0]);
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rr_ptr_d        = rr_ptr_q;
        avm_write_d     = avm_write_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    grant_d         = sel_lane;
                    avm_address_d   = BUFFER_ADDR_W'(FB_BASE) +
                                      BUFFER_ADDR_W'(CORE_STRIDE) * BUFFER_ADDR_W'(sel_lane) +
                                      BUFFER_ADDR_W'(head.addr);
                    avm_writedata_d = COLOR_WIDTH'(head.data);
                    avm_write_d     = 1'b1;
                    state_d         = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!avm_waitrequest) begin
                    avm_write_d = 1'b0;
                    rr_ptr_d    = (grant_q == LANE_W'(CORES_COUNT - 1)) ? '0 : grant_q + LANE_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pending end-of-frame only completes once nothing is queued or in flight.
    assign frame_done = pending_q && (state_q == ST_IDLE) && all_empty;

    always_comb begin
        pending_d  = eoc_in || (pending_q && !frame_done);
        overflow_d = overflow_q || (|fifo_drop);
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            rr_ptr_q        <= '0;
            avm_write_q     <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            pending_q       <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            rr_ptr_q        <= rr_ptr_d;
            avm_write_q     <= avm_write_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            pending_q       <= pending_d;
            overflow_q      <= overflow_d;
        end
    end

    assign avm_write     = avm_write_q;
    assign avm_address   = avm_address_q;
    assign avm_writedata = avm_writedata_q;
    assign overflow      = overflow_q;
    assign busy          = !all_empty || (state_q == ST_WRITE);

`ifdef PIXEL_WRITE_DROP_COUNT_EN
    logic [31:0] drop_count_q, drop_count_d;
    logic [32:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_count_q};
        for (int i = 0; i < CORES_COUNT; i++) begin
            drop_sum = drop_sum + 33'(fifo_drop[i]);
        end
        drop_count_d = drop_sum[32] ? '1 : drop_sum[31:0];
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_pixel_write_arbiter : directed self-checking bench for pixel_write_arbiter
// Rev 1.0
// ============================================================================
module tb_pixel_write_arbiter;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] ppu_data    [0:N-1];
    logic [31:0] ppu_address [0:N-1];
    logic        ppu_valid   [0:N-1];
    logic        eoc_in;
    logic [31:0] avm_address;
    logic [15:0] avm_writedata;
    logic        avm_write;
    logic        avm_waitrequest;
    logic        busy;
    logic        frame_done;
    logic        overflow;
`ifdef PIXEL_WRITE_DROP_COUNT_EN
    logic [31:0] drop_count;
`endif

    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;

    pixel_write_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ppu_data        (ppu_data),
        .ppu_address     (ppu_address),
        .ppu_valid       (ppu_valid),
        .eoc_in          (eoc_in),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_write       (avm_write),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .frame_done      (frame_done),
        .overflow        (overflow)
`ifdef PIXEL_WRITE_DROP_COUNT_EN
        ,
        .drop_count      (drop_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            ppu_valid[i]   = 1'b0;
            ppu_data[i]    = '0;
            ppu_address[i] = '0;
        end
        eoc_in = 1'b0;
    endtask

    task automatic send(input int lane, input logic [15:0] d, input logic [31:0] a);
        ppu_valid[lane]   = 1'b1;
        ppu_data[lane]    = d;
        ppu_address[lane] = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        fd_cnt = 0;
        @(negedge clk);
        reset_n = 1'b0;
    endtask

    task automatic wait_write(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (avm_write) found = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_write_seen"}, 64'(found), 64'd1);
    endtask

    task automatic wait_accept(input string tag, input logic [31:0] ea, input logic [15:0] ed);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (avm_write && !avm_waitrequest) found = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_accept_seen"}, 64'(found), 64'd1);
        check({tag, "_addr"}, 64'(avm_address), 64'(ea));
        check({tag, "_data"}, 64'(avm_writedata), 64'(ed));
        @(negedge clk);
    endtask

    initial begin
        int acc;
        reset_n         = 1'b1;
        avm_waitrequest = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check("rst_avm_write", 64'(avm_write), 64'd0);
        check("rst_avm_address", 64'(avm_address), 64'd0);
        check("rst_avm_writedata", 64'(avm_writedata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
`ifdef PIXEL_WRITE_DROP_COUNT_EN
        check("rst_drop_count", 64'(drop_count), 64'd0);
`endif
        reset_n = 1'b0;
        @(negedge clk);

        // Single pixel on lane 3: write visible in the cycle after edge N+1.
        send(3, 16'h1234, 32'd8);
        @(negedge clk);
        clear_inputs();
        check("single_no_write_yet", 64'(avm_write), 64'd0);
        check("single_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("single_write", 64'(avm_write), 64'd1);
        check("single_addr", 64'(avm_address), 64'd576008);
        check("single_data", 64'(avm_writedata), 64'h1234);
        @(negedge clk);
        check("single_done_write", 64'(avm_write), 64'd0);
        check("single_done_busy", 64'(busy), 64'd0);

        // Round robin from rr_ptr=0, then wrap back to lane 0.
        do_reset();
        send(0, 16'h00A0, 32'h10);
        send(1, 16'h00A1, 32'h20);
        send(9, 16'h00A9, 32'h30);
        @(negedge clk);
        clear_inputs();
        wait_accept("rr_lane0", 32'd16, 16'h00A0);
        wait_accept("rr_lane1", 32'd192032, 16'h00A1);
        wait_accept("rr_lane9", 32'd1728048, 16'h00A9);
        send(5, 16'h00B5, 32'h50);
        send(0, 16'h00B0, 32'h40);
        @(negedge clk);
        clear_inputs();
        wait_accept("rr_wrap_lane0", 32'd64, 16'h00B0);
        wait_accept("rr_wrap_lane5", 32'd960080, 16'h00B5);

        // Backpressure: request held stable, exactly one accept.
        do_reset();
        avm_waitrequest = 1'b1;
        send(2, 16'hBEEF, 32'd4);
        @(negedge clk);
        clear_inputs();
        wait_write("bp");
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_write", 64'(avm_write), 64'd1);
            check("bp_hold_addr", 64'(avm_address), 64'd384004);
            check("bp_hold_data", 64'(avm_writedata), 64'hBEEF);
            if (avm_write && !avm_waitrequest) acc++;
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (avm_write && !avm_waitrequest) acc++;
            @(negedge clk);
        end
        check("bp_accepts", 64'(acc), 64'd1);
        check("bp_idle_write", 64'(avm_write), 64'd0);

        // Overflow: 12 pushes into a stalled lane keep 8, drop 4.
        do_reset();
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 12; k++) begin
            send(0, 16'(k), 32'(k * 4));
            @(negedge clk);
        end
        clear_inputs();
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_busy", 64'(busy), 64'd1);
`ifdef PIXEL_WRITE_DROP_COUNT_EN
        check("ovf_drop_count", 64'(drop_count), 64'd4);
`endif
        avm_waitrequest = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_accept("ovf_drain", 32'(k * 4), 16'(k));
        end
        repeat (3) @(negedge clk);
        check("ovf_no_extra_write", 64'(avm_write), 64'd0);
        check("ovf_drained_busy", 64'(busy), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Frame end: eoc with the last pushes, done after the third accept.
        do_reset();
        send(0, 16'h0C00, 32'd0);
        send(1, 16'h0C01, 32'd2);
        send(2, 16'h0C02, 32'd6);
        eoc_in = 1'b1;
        @(negedge clk);
        clear_inputs();
        check("fd_not_early", 64'(frame_done), 64'd0);
        wait_accept("fd_w0", 32'd0, 16'h0C00);
        wait_accept("fd_w1", 32'd192002, 16'h0C01);
        wait_accept("fd_w2", 32'd384006, 16'h0C02);
        check("fd_pulse", 64'(frame_done), 64'd1);
        @(negedge clk);
        check("fd_pulse_end", 64'(frame_done), 64'd0);
        repeat (3) @(negedge clk);
        check("fd_count", 64'(fd_cnt), 64'd1);

        // Reset during a stalled write discards everything.
        do_reset();
        avm_waitrequest = 1'b1;
        send(4, 16'h0D04, 32'd12);
        send(6, 16'h0D06, 32'd14);
        eoc_in = 1'b1;
        @(negedge clk);
        clear_inputs();
        wait_write("mid");
        reset_n = 1'b1;
        #1;
        check("mid_async_write", 64'(avm_write), 64'd0);
        check("mid_async_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n         = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_after_busy", 64'(busy), 64'd0);
        check("mid_after_write", 64'(avm_write), 64'd0);
        check("mid_no_frame_done", 64'(fd_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_write_arbiter.md
PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 SHALL have parameter CORES_COUNT, default 10, number of PPU lanes.
REQ-002 SHALL have parameter COLOR_WIDTH, default 16, pixel data width.
REQ-003 SHALL have parameter BUFFER_ADDR_W, default 32, address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, entries per lane (power of 2, at least 2).
REQ-005 SHALL have parameter FB_BASE, default 0, framebuffer byte base address.
REQ-006 SHALL have parameter CORE_STRIDE, default 192000, byte offset between lane regions (800*60*4).
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port reset_n, input, 1, reset: asynchronous, active-high.
REQ-009 SHALL have ports ppu_data, ppu_address and ppu_valid, all inputs, arrays [0:CORES_COUNT-1] of COLOR_WIDTH, BUFFER_ADDR_W and 1 bits, carrying the per-lane pixel stream with lane-local byte address.
REQ-010 SHALL have port eoc_in, input, 1, upstream end-of-computation pulse.
REQ-011 SHALL have ports avm_address (output, BUFFER_ADDR_W), avm_writedata (output, COLOR_WIDTH), avm_write (output, 1) and avm_waitrequest (input, 1), forming the memory write master.
REQ-012 SHALL have port busy, output, 1, high when any FIFO is non-empty or a write is in flight.
REQ-013 SHALL have port frame_done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port overflow, output, 1, sticky flag set when any pixel is dropped.

Function
REQ-015 SHALL give each lane a FIFO that pushes {ppu_address, ppu_data} at the clock edge where ppu_valid is high and the FIFO is not full.
REQ-016 SHALL drop a valid pixel arriving at a full FIFO and set overflow; overflow clears only on reset.
REQ-017 SHALL accept a push on a full FIFO when a pop occurs in the same cycle, with no drop.
REQ-018 SHALL implement the master FSM with states IDLE and WRITE.
REQ-019 SHALL, in IDLE with at least one non-empty FIFO, grant the first non-empty lane at or after rr_ptr (modulo CORES_COUNT), register the request and enter WRITE.
REQ-020 SHALL hold avm_write high in WRITE with avm_address and avm_writedata stable while avm_waitrequest is high.
REQ-021 SHALL treat avm_write high with avm_waitrequest low as accept: pop the granted FIFO, set rr_ptr to grant+1 (wrapping to 0 after CORES_COUNT-1), and return to IDLE.
REQ-022 SHALL compute avm_address = FB_BASE + grant*CORE_STRIDE + stored lane address, truncated to BUFFER_ADDR_W.
REQ-023 SHALL give a latency of 2 cycles from valid at edge N to the earliest avm_write, which is high in the cycle after edge N+1, and SHALL allow at most one accept every 2 cycles.
REQ-024 SHALL latch eoc_in into a pending flag; when the flag is set, the FSM is IDLE and all FIFOs are empty, it SHALL pulse frame_done for exactly 1 cycle and clear the flag.
REQ-025 SHALL, when eoc_in coincides with the last push, defer frame_done until that pixel has been written.

Reset
REQ-026 SHALL, on reset_n high, immediately and asynchronously set avm_write=0, avm_address=0, avm_writedata=0, busy=0, frame_done=0, overflow=0, all FIFOs empty, rr_ptr=0, pending=0 and FSM=IDLE.
REQ-027 SHALL discard any in-flight write and all queued pixels when reset asserts mid-operation, with no completion reported.

Configuration
REQ-028 SHALL, when macro PIXEL_WRITE_DROP_COUNT_EN is defined, add output drop_count (32 bits), reset to 0, that increments by the number of lanes dropping in that cycle and saturates at all-ones.
REQ-029 SHALL, when PIXEL_WRITE_DROP_COUNT_EN is undefined, omit the drop_count port and its logic; overflow is unaffected.

Structure
REQ-030 SHALL place the FSM state enum and the lane entry struct {addr, data} in shared package gpu_pkg.
REQ-031 SHALL implement each lane FIFO as sub-module pixel_fifo, with parameters WIDTH and DEPTH, and ports push, pop, din, dout, full and empty.

Verification
REQ-032 SHALL verify single pixel: lane 3 sends data 0x1234, addr 8, waitrequest=0 -> one write with address 3*192000+8=576008 and data 0x1234, 2 cycles after the valid edge.
REQ-033 SHALL verify round-robin: lanes 0, 1 and 9 each send one pixel in the same cycle -> writes in order lane 0, 1, 9, then rr_ptr=0.
REQ-034 SHALL verify backpressure: waitrequest held high for 5 cycles -> address and data stable for 5 cycles, exactly one accept, no duplicate write.
REQ-035 SHALL verify overflow: lane 0 valid for 12 consecutive cycles with waitrequest=1 -> 8 pixels stored, overflow=1, drop_count=4 when the macro is defined.
REQ-036 SHALL verify frame end: eoc_in pulses with 3 pixels queued -> frame_done pulses exactly once, in the cycle after the third accept.
REQ-037 SHALL verify reset mid-write: reset_n high while avm_write=1 -> avm_write=0 in the same cycle, and after release busy=0 with no frame_done.
